mem_wb_pipe_reg: RTL and testbench
==================================

// Module: mem_wb_pipe_reg
// PURPOSE
//   MEM/WB pipeline register of the 5-stage 64-bit RISC-V core.
//   Captures the MEM-stage results at each rising clock edge and presents them to the WB stage:
//   - WB control bits (RegWrite, MemtoReg)
//   - load data read from data memory
//   - the ALU result
//   - the destination register index
//   Pure storage. No decoding, no muxing; the WB writeback mux is outside this block.
// PARAMETERS
//   DATA_W      64   width of memory load data and ALU result
//   REG_ADDR_W  5    width of the register-file index (32 regs)
// PORTS
//   clk             in   1           single clock, rising-edge active
//   reset           in   1           asynchronous, active-low reset (0 = reset asserted)
//   RegWrite        in   1           MEM-stage: instruction writes the register file
//   MemtoReg        in   1           MEM-stage: WB selects memory data (1) or ALU result (0)
//   Dataout_Memory  in   DATA_W      data read from data memory in MEM
//   AluOut_in       in   DATA_W      ALU result carried through MEM
//   Rd_in           in   REG_ADDR_W  destination register index
//   RegWrite_Out    out  1           registered RegWrite
//   MemtoReg_Out    out  1           registered MemtoReg
//   DataOut         out  DATA_W      registered Dataout_Memory
//   AluOut          out  DATA_W      registered AluOut_in
//   Rd_out          out  REG_ADDR_W  registered Rd_in
// BEHAVIOUR
//   Reset:
//   - While reset==0, all outputs are 0, immediately, independent of clk.
//   - RegWrite_Out=0, MemtoReg_Out=0, DataOut=0, AluOut=0, Rd_out=0.
//   - A zeroed register is a bubble: RegWrite_Out=0, so no writeback occurs.
//   Capture:
//   - On posedge clk with reset==1, every output takes its input's value from that edge.
//   - Latency is exactly 1 cycle. Outputs hold stable between edges.
//   - There is no enable, stall or flush port; the register loads on every edge.
//   - Hazard and flush handling lives in upstream registers.
//   Reset mid-operation:
//   - Assertion clears all outputs asynchronously, with no clock edge needed.
//   - Deassertion is taken synchronously by the integrator.
//   - The first capture happens on the first posedge with reset==1.
//   Data handling:
//   - No width conversion, sign extension or masking; values pass bit-exact.
//   - Rd_in==0 is passed through unchanged; x0 suppression belongs to the register file.
//   - All outputs are driven directly from flops; there is no combinational path from input to output.
// STRUCTURE
//   - Shared package core_pkg holds DATA_W=64 and REG_ADDR_W=5 as the core-wide constants.
//   - Optional wb_ctrl_t packed struct {RegWrite, MemtoReg}, reused by the EX/MEM register.
//   - One natural sub-module: pipe_reg
//     - Generic WIDTH-parameterised flop with async active-low clear.
//     - Instantiated once per field, or once on the concatenated bundle.
//   - Top level: parameter checks (DATA_W>0, REG_ADDR_W>0) plus field wiring.
// TESTING
//   1. Reset hold: reset=0, all inputs 0, run 2 cycles -> all outputs 0.
//      Then with reset=0, drive inputs to all-ones -> outputs stay 0.
//   2. Single capture: reset=1.
//      Drive RegWrite=1, MemtoReg=1, Dataout_Memory=64'hDEAD_BEEF_0123_4567,
//      AluOut_in=64'h0000_0000_0000_0010, Rd_in=5'd7.
//      After one posedge -> outputs equal those values. Unchanged before that edge.
//   3. Back-to-back: change inputs every cycle (Rd 1,2,3; AluOut 64'h1,64'h2,64'h3)
//      -> each output sequence is the input sequence delayed by exactly 1 cycle.
//   4. Async reset mid-run: with outputs holding Rd_out=5'd31 and AluOut=64'hFFFF_FFFF_FFFF_FFFF,
//      pull reset low between edges -> all outputs 0 within the same timestep,
//      before the next posedge.
//   5. Load vs ALU path: MemtoReg=0, RegWrite=1, Dataout_Memory=64'hAAAA..., AluOut_in=64'h5555...
//      -> both data outputs captured independently.
//      Then RegWrite=0, Rd_in=0 -> RegWrite_Out=0, Rd_out=0.

Source files
------------

// File: rtl/core_pkg.sv
// Core-wide constants and the WB control bundle shared by the pipeline registers.
package core_pkg;

  localparam int DATA_W     = 64;
  localparam int REG_ADDR_W = 5;

  // WB-stage control bits carried through the EX/MEM and MEM/WB registers.
  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } wb_ctrl_t;

  localparam wb_ctrl_t WB_BUBBLE = '{reg_write: 1'b0, mem_to_reg: 1'b0};

endpackage

// File: rtl/mem_wb_pipe_reg_pipe_reg.sv
// Generic WIDTH-bit register.
// Loads on every rising edge and clears asynchronously when rst_ni is low.
module pipe_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
    end else begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/mem_wb_pipe_reg.sv
// MEM/WB pipeline register of the 64-bit RISC-V core.
// All MEM-stage results are held in one flop bundle and presented to WB one cycle later.
module mem_wb_pipe_reg
  import core_pkg::*;
#(
  parameter int DATA_W     = core_pkg::DATA_W,
  parameter int REG_ADDR_W = core_pkg::REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  RegWrite,
  input  logic                  MemtoReg,
  input  logic [DATA_W-1:0]     Dataout_Memory,
  input  logic [DATA_W-1:0]     AluOut_in,
  input  logic [REG_ADDR_W-1:0] Rd_in,
  output logic                  RegWrite_Out,
  output logic                  MemtoReg_Out,
  output logic [DATA_W-1:0]     DataOut,
  output logic [DATA_W-1:0]     AluOut,
  output logic [REG_ADDR_W-1:0] Rd_out
);

  localparam int CTRL_W   = $bits(wb_ctrl_t);
  localparam int BUNDLE_W = CTRL_W + 2 * DATA_W + REG_ADDR_W;

  generate
    if (DATA_W <= 0) begin : g_bad_data_w
      $error("mem_wb_pipe_reg: DATA_W must be positive");
    end
    if (REG_ADDR_W <= 0) begin : g_bad_reg_addr_w
      $error("mem_wb_pipe_reg: REG_ADDR_W must be positive");
    end
  endgenerate

  wb_ctrl_t              ctrl_d;
  wb_ctrl_t              ctrl_q;
  logic [BUNDLE_W-1:0]   bundle_d;
  logic [BUNDLE_W-1:0]   bundle_q;

  assign ctrl_d   = '{reg_write: RegWrite, mem_to_reg: MemtoReg};
  assign bundle_d = {ctrl_d, Dataout_Memory, AluOut_in, Rd_in};

  // A cleared bundle is a bubble: reg_write=0 suppresses writeback.
  pipe_reg #(
    .WIDTH (BUNDLE_W)
  ) u_bundle_reg (
    .clk_i  (clk),
    .rst_ni (reset),
    .d_i    (bundle_d),
    .q_o    (bundle_q)
  );

  assign {ctrl_q, DataOut, AluOut, Rd_out} = bundle_q;
  assign RegWrite_Out = ctrl_q.reg_write;
  assign MemtoReg_Out = ctrl_q.mem_to_reg;

endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// Directed and random bench for mem_wb_pipe_reg with an expected-value queue.
module tb_mem_wb_pipe_reg;

  localparam int DW = 64;
  localparam int RW = 5;
  localparam int W  = 2 + 2 * DW + RW;

  logic          clk;
  logic          reset;
  logic          RegWrite;
  logic          MemtoReg;
  logic [DW-1:0] Dataout_Memory;
  logic [DW-1:0] AluOut_in;
  logic [RW-1:0] Rd_in;
  logic          RegWrite_Out;
  logic          MemtoReg_Out;
  logic [DW-1:0] DataOut;
  logic [DW-1:0] AluOut;
  logic [RW-1:0] Rd_out;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_exp;
  int tests;
  int fails;

  mem_wb_pipe_reg dut (
    .clk            (clk),
    .reset          (reset),
    .RegWrite       (RegWrite),
    .MemtoReg       (MemtoReg),
    .Dataout_Memory (Dataout_Memory),
    .AluOut_in      (AluOut_in),
    .Rd_in          (Rd_in),
    .RegWrite_Out   (RegWrite_Out),
    .MemtoReg_Out   (MemtoReg_Out),
    .DataOut        (DataOut),
    .AluOut         (AluOut),
    .Rd_out         (Rd_out)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // driver: apply inputs; when out of reset the next edge must capture them
  task automatic drive(input logic rw, input logic m2r, input logic [DW-1:0] mem,
                       input logic [DW-1:0] alu, input logic [RW-1:0] rd);
    RegWrite       = rw;
    MemtoReg       = m2r;
    Dataout_Memory = mem;
    AluOut_in      = alu;
    Rd_in          = rd;
    if (reset) exp_q.push_back({rw, m2r, mem, alu, rd});
  endtask

  task automatic check(input string tag, input logic [W-1:0] exp);
    logic [W-1:0] obs;
    obs = {RegWrite_Out, MemtoReg_Out, DataOut, AluOut, Rd_out};
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // scoreboard: pop one expected entry per capturing edge
  task automatic check_pop(input string tag);
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s: scoreboard queue empty", tag);
    end else begin
      last_exp = exp_q.pop_front();
      check(tag, last_exp);
    end
  endtask

  task automatic step_and_check(input string tag);
    @(posedge clk);
    #1;
    check_pop(tag);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b0;
    drive(1'b0, 1'b0, '0, '0, '0);

    // 1. reset hold
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", '0);
    @(negedge clk);
    drive(1'b1, 1'b1, '1, '1, '1);
    @(posedge clk);
    #1;
    check("reset_ones_edge1", '0);
    @(posedge clk);
    #1;
    check("reset_ones_edge2", '0);

    // 2. single capture
    @(negedge clk);
    reset = 1'b1;
    drive(1'b1, 1'b1, 64'hDEAD_BEEF_0123_4567, 64'h0000_0000_0000_0010, 5'd7);
    #1;
    check("single_before_edge", '0);
    step_and_check("single_capture");
    #3;
    check("single_hold", last_exp);

    // 3. back-to-back
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      drive(i[0], ~i[0], 64'(i * 16), 64'(i), 5'(i));
      #1;
      if (i > 1) check("b2b_prev_held", last_exp);
      step_and_check("b2b_capture");
    end

    // 4. async reset mid-cycle
    @(negedge clk);
    drive(1'b1, 1'b0, 64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31);
    step_and_check("pre_async_capture");
    #2;
    reset = 1'b0;
    #1;
    check("async_clear", '0);
    @(posedge clk);
    #1;
    check("async_hold_edge", '0);
    @(negedge clk);
    reset = 1'b1;

    // 5. load vs ALU path, then bubble with rd=0
    drive(1'b1, 1'b0, 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 5'd12);
    step_and_check("load_vs_alu");
    @(negedge clk);
    drive(1'b0, 1'b1, 64'h1357_9BDF_2468_ACE0, 64'h0F0F_0F0F_F0F0_F0F0, 5'd0);
    step_and_check("bubble_rd0");

    // random back-to-back traffic
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
            {32'($urandom), 32'($urandom)}, {32'($urandom), 32'($urandom)},
            5'($urandom_range(31, 0)));
      step_and_check("random");
    end

    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $error("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
